// File: rtl/draw_sprite_if.sv
// VGA timing/pixel bus passed between video pipeline blocks.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_sprite.sv
// Overlays a SPRITE_W x SPRITE_H ROM sprite onto a VGA stream with a fixed 2-clk delay.
// The sprite position is latched at the start of vertical blanking, so it never tears mid-frame.
module draw_sprite #(
  parameter int          SPRITE_W  = 32,
  parameter int          SPRITE_H  = 32,
  parameter logic [11:0] KEY_COLOR = 12'hF0F
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [10:0]                            xpos,
  input  logic [10:0]                            ypos,
  output logic [$clog2(SPRITE_W*SPRITE_H)-1:0]   rom_addr,
  input  logic [11:0]                            rom_data,
  vga_if.in                                      in,
  vga_if.out                                     out
);

  localparam int          AW  = $clog2(SPRITE_W*SPRITE_H);
  localparam int          XW  = $clog2(SPRITE_W);
  localparam int          YW  = AW - XW;
  localparam logic [11:0] W12 = 12'(SPRITE_W);
  localparam logic [11:0] H12 = 12'(SPRITE_H);

  function automatic logic [11:0] pick_rgb(input logic        draw,
                                           input logic [11:0] spr,
                                           input logic [11:0] bg);
    return (draw && (spr != KEY_COLOR)) ? spr : bg;
  endfunction

  logic          vblnk_p0_q;
  logic [10:0]   xpos_q, xpos_d;
  logic [10:0]   ypos_q, ypos_d;
  logic          load_p0;
  logic [11:0]   hc12, vc12, x12, y12;
  logic [XW-1:0] dx_p0;
  logic [YW-1:0] dy_p0;
  logic          inside_d;
  logic [AW-1:0] rom_addr_d;

  logic [10:0]   hcount_p1_q, vcount_p1_q;
  logic          hsync_p1_q, vsync_p1_q, hblnk_p1_q, vblnk_p1_q;
  logic [11:0]   rgb_p1_q;
  logic          inside_p1_q;
  logic [AW-1:0] rom_addr_q;

  logic [10:0]   hcount_p2_q, vcount_p2_q;
  logic          hsync_p2_q, vsync_p2_q, hblnk_p2_q, vblnk_p2_q;
  logic [11:0]   rgb_p2_q, rgb_p2_d;

  // Stage 0: position latch on vblnk rising edge, hit test and ROM address
  always_comb begin
    load_p0  = in.vblnk & ~vblnk_p0_q;
    xpos_d   = load_p0 ? xpos : xpos_q;
    ypos_d   = load_p0 ? ypos : ypos_q;
    hc12     = {1'b0, in.hcount};
    vc12     = {1'b0, in.vcount};
    x12      = {1'b0, xpos_q};
    y12      = {1'b0, ypos_q};
    inside_d = (hc12 >= x12) && (hc12 < (x12 + W12)) &&
               (vc12 >= y12) && (vc12 < (y12 + H12)) &&
               !in.hblnk && !in.vblnk;
    // SPRITE_W is a power of two, so row*W + col is a plain concatenation.
    dx_p0      = XW'(in.hcount - xpos_q);
    dy_p0      = YW'(in.vcount - ypos_q);
    rom_addr_d = inside_d ? {dy_p0, dx_p0} : '0;
  end

  // Stage 2 pixel select: ROM data arrives alongside the stage-1 registers
  always_comb begin
    rgb_p2_d = pick_rgb(inside_p1_q, rom_data, rgb_p1_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vblnk_p0_q  <= 1'b0;
      xpos_q      <= '0;
      ypos_q      <= '0;
      hcount_p1_q <= '0;
      vcount_p1_q <= '0;
      hsync_p1_q  <= 1'b0;
      vsync_p1_q  <= 1'b0;
      hblnk_p1_q  <= 1'b0;
      vblnk_p1_q  <= 1'b0;
      rgb_p1_q    <= '0;
      inside_p1_q <= 1'b0;
      rom_addr_q  <= '0;
      hcount_p2_q <= '0;
      vcount_p2_q <= '0;
      hsync_p2_q  <= 1'b0;
      vsync_p2_q  <= 1'b0;
      hblnk_p2_q  <= 1'b0;
      vblnk_p2_q  <= 1'b0;
      rgb_p2_q    <= '0;
    end else begin
      vblnk_p0_q  <= in.vblnk;
      xpos_q      <= xpos_d;
      ypos_q      <= ypos_d;
      // Stage 1
      hcount_p1_q <= in.hcount;
      vcount_p1_q <= in.vcount;
      hsync_p1_q  <= in.hsync;
      vsync_p1_q  <= in.vsync;
      hblnk_p1_q  <= in.hblnk;
      vblnk_p1_q  <= in.vblnk;
      rgb_p1_q    <= in.rgb;
      inside_p1_q <= inside_d;
      rom_addr_q  <= rom_addr_d;
      // Stage 2
      hcount_p2_q <= hcount_p1_q;
      vcount_p2_q <= vcount_p1_q;
      hsync_p2_q  <= hsync_p1_q;
      vsync_p2_q  <= vsync_p1_q;
      hblnk_p2_q  <= hblnk_p1_q;
      vblnk_p2_q  <= vblnk_p1_q;
      rgb_p2_q    <= rgb_p2_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign out.hcount = hcount_p2_q;
  assign out.vcount = vcount_p2_q;
  assign out.hsync  = hsync_p2_q;
  assign out.vsync  = vsync_p2_q;
  assign out.hblnk  = hblnk_p2_q;
  assign out.vblnk  = vblnk_p2_q;
  assign out.rgb    = rgb_p2_q;

endmodule

// File: tb/tb_draw_sprite.sv
// Directed bench for draw_sprite: vector table plus latency, latch-timing and reset sequences.
module tb_draw_sprite;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [10:0]   xpos, ypos;
  logic [AW-1:0] rom_addr;
  logic [11:0]   rom_data;
  int            n_cmp = 0;
  int            n_err = 0;

  vga_if vin();
  vga_if vout();

  draw_sprite dut (
    .clk      (clk),
    .rst      (rst),
    .xpos     (xpos),
    .ypos     (ypos),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .in       (vin),
    .out      (vout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0]   hc;
    logic [10:0]   vc;
    logic          hs, vs, hb, vb;
    logic [11:0]   rgb;
    logic [11:0]   rom;
    logic [AW-1:0] addr;
    logic [11:0]   exp_rgb;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(input logic [10:0] hc, input logic [10:0] vc,
                              input logic hs, input logic vs, input logic hb, input logic vb,
                              input logic [11:0] rgb, input logic [11:0] rom,
                              input logic [AW-1:0] addr, input logic [11:0] exp_rgb);
    vec_t v;
    v.hc = hc; v.vc = vc; v.hs = hs; v.vs = vs; v.hb = hb; v.vb = vb;
    v.rgb = rgb; v.rom = rom; v.addr = addr; v.exp_rgb = exp_rgb;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_in(input logic [10:0] hc, input logic [10:0] vc,
                          input logic hs, input logic vs, input logic hb, input logic vb,
                          input logic [11:0] rgb);
    vin.hcount = hc; vin.vcount = vc;
    vin.hsync = hs; vin.vsync = vs; vin.hblnk = hb; vin.vblnk = vb;
    vin.rgb = rgb;
  endtask

  function automatic logic [25:0] out_tim();
    return {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk};
  endfunction

  // Inputs are held for two cycles; ROM data is supplied the cycle after the address.
  task automatic apply(input vec_t v, input string tag);
    drive_in(v.hc, v.vc, v.hs, v.vs, v.hb, v.vb, v.rgb);
    rom_data = 12'h000;
    @(negedge clk);
    check({tag, ".addr"}, 32'(rom_addr), 32'(v.addr));
    rom_data = v.rom;
    @(negedge clk);
    check({tag, ".rgb"}, 32'(vout.rgb), 32'(v.exp_rgb));
    check({tag, ".tim"}, 32'(out_tim()), 32'({v.hc, v.vc, v.hs, v.vs, v.hb, v.vb}));
  endtask

  logic [10:0] lat_hc [4];
  logic        lat_hs [4];
  logic [11:0] lat_rgb[4];

  initial begin
    tbl[0]  = mk(11'd205, 11'd103, 1'b0, 1'b0, 1'b0, 1'b0, 12'h111, 12'hABC, 10'd101,  12'hABC);
    tbl[1]  = mk(11'd205, 11'd103, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F0, 12'hF0F, 10'd101,  12'h0F0);
    tbl[2]  = mk(11'd231, 11'd103, 1'b0, 1'b0, 1'b0, 1'b0, 12'h111, 12'h456, 10'd127,  12'h456);
    tbl[3]  = mk(11'd232, 11'd103, 1'b0, 1'b0, 1'b0, 1'b0, 12'h222, 12'h789, 10'd0,    12'h222);
    tbl[4]  = mk(11'd199, 11'd103, 1'b0, 1'b0, 1'b0, 1'b0, 12'h333, 12'h789, 10'd0,    12'h333);
    tbl[5]  = mk(11'd210, 11'd103, 1'b0, 1'b0, 1'b1, 1'b0, 12'h444, 12'h789, 10'd0,    12'h444);
    tbl[6]  = mk(11'd200, 11'd100, 1'b0, 1'b0, 1'b0, 1'b0, 12'h555, 12'h0AA, 10'd0,    12'h0AA);
    tbl[7]  = mk(11'd231, 11'd131, 1'b0, 1'b0, 1'b0, 1'b0, 12'h666, 12'h0BB, 10'd1023, 12'h0BB);
    tbl[8]  = mk(11'd231, 11'd132, 1'b0, 1'b0, 1'b0, 1'b0, 12'h777, 12'h0CC, 10'd0,    12'h777);
    tbl[9]  = mk(11'd215, 11'd99,  1'b0, 1'b0, 1'b0, 1'b0, 12'h888, 12'h0CC, 10'd0,    12'h888);
    tbl[10] = mk(11'd220, 11'd110, 1'b1, 1'b1, 1'b0, 1'b0, 12'h999, 12'h0DD, 10'd340,  12'h0DD);
    tbl[11] = mk(11'd210, 11'd105, 1'b0, 1'b0, 1'b0, 1'b1, 12'hAAA, 12'h0DD, 10'd0,    12'hAAA);

    lat_hc[0] = 11'd99;  lat_hs[0] = 1'b0; lat_rgb[0] = 12'h000;
    lat_hc[1] = 11'd100; lat_hs[1] = 1'b1; lat_rgb[1] = 12'h123;
    lat_hc[2] = 11'd101; lat_hs[2] = 1'b0; lat_rgb[2] = 12'h321;
    lat_hc[3] = 11'd102; lat_hs[3] = 1'b0; lat_rgb[3] = 12'h456;

    // Reset held with live input: everything must read zero
    rst = 1'b0; xpos = 11'd0; ypos = 11'd0; rom_data = 12'hFFF;
    drive_in(11'd5, 11'd7, 1'b1, 1'b1, 1'b0, 1'b0, 12'hFFF);
    @(negedge clk); @(negedge clk);
    check("rst.tim",  32'(out_tim()), 32'd0);
    check("rst.rgb",  32'(vout.rgb), 32'd0);
    check("rst.addr", 32'(rom_addr), 32'd0);

    // Release and latch sprite at (200,100) on a vblnk rising edge
    rst = 1'b1; xpos = 11'd200; ypos = 11'd100;
    drive_in(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    @(negedge clk);
    check("pre.xpos_q", 32'(dut.xpos_q), 32'd0);
    vin.vblnk = 1'b1;
    @(negedge clk);
    vin.vblnk = 1'b0;
    check("load.xpos_q", 32'(dut.xpos_q), 32'd200);
    check("load.ypos_q", 32'(dut.ypos_q), 32'd100);

    for (int i = 0; i < 12; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Exactly two clocks from in to out, one-cycle pulse in the middle
    for (int i = 0; i < 4; i++) begin
      drive_in(lat_hc[i], 11'd50, lat_hs[i], 1'b0, 1'b0, 1'b0, lat_rgb[i]);
      @(negedge clk);
      if (i >= 1)
        check($sformatf("lat%0d", i), 32'({vout.hcount, vout.vcount, vout.hsync, vout.rgb}),
              32'({lat_hc[i-1], 11'd50, lat_hs[i-1], lat_rgb[i-1]}));
    end
    @(negedge clk);
    check("lat4", 32'({vout.hcount, vout.vcount, vout.hsync, vout.rgb}),
          32'({lat_hc[3], 11'd50, lat_hs[3], lat_rgb[3]}));

    // Mid-frame position change is ignored until the next vblnk rising edge
    xpos = 11'd300;
    apply(mk(11'd205, 11'd103, 1'b0, 1'b0, 1'b0, 1'b0, 12'h111, 12'h0AB, 10'd101, 12'h0AB), "mid.old");
    check("mid.xpos_q", 32'(dut.xpos_q), 32'd200);
    apply(mk(11'd305, 11'd103, 1'b0, 1'b0, 1'b0, 1'b0, 12'h222, 12'h0AB, 10'd0, 12'h222), "mid.new");
    drive_in(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    @(negedge clk);
    vin.vblnk = 1'b1;
    @(negedge clk);
    check("edge.xpos_q", 32'(dut.xpos_q), 32'd300);
    xpos = 11'd400;
    @(negedge clk);
    check("hold.xpos_q", 32'(dut.xpos_q), 32'd300);
    vin.vblnk = 1'b0;
    apply(mk(11'd305, 11'd103, 1'b0, 1'b0, 1'b0, 1'b0, 12'h222, 12'h0AB, 10'd101, 12'h0AB), "next.new");
    apply(mk(11'd205, 11'd103, 1'b0, 1'b0, 1'b0, 1'b0, 12'h111, 12'h0AB, 10'd0, 12'h111), "next.old");

    // Asynchronous reset mid-line while the sprite is being drawn
    drive_in(11'd305, 11'd103, 1'b1, 1'b0, 1'b0, 1'b0, 12'h111);
    rom_data = 12'h0AB;
    @(negedge clk); @(negedge clk);
    check("act.rgb", 32'(vout.rgb), 32'h0AB);
    #2 rst = 1'b0;
    #1;
    check("arst.tim",    32'(out_tim()), 32'd0);
    check("arst.rgb",    32'(vout.rgb), 32'd0);
    check("arst.addr",   32'(rom_addr), 32'd0);
    check("arst.xpos_q", 32'(dut.xpos_q), 32'd0);
    check("arst.ypos_q", 32'(dut.ypos_q), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    // Without a new vblnk edge the sprite sits at the origin
    apply(mk(11'd10, 11'd5, 1'b0, 1'b0, 1'b0, 1'b0, 12'h111, 12'h0EE, 10'd170, 12'h0EE), "post.draw");
    apply(mk(11'd305, 11'd103, 1'b1, 1'b0, 1'b0, 1'b0, 12'h222, 12'h0EE, 10'd0, 12'h222), "post.pass");
    check("post.xpos_q", 32'(dut.xpos_q), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/draw_sprite.md
DRAW_SPRITE -- requirements
Module: draw_sprite

Interface
REQ-001 SHALL have parameter SPRITE_W, default 32, sprite width in pixels (power of two).
REQ-002 SHALL have parameter SPRITE_H, default 32, sprite height in pixels.
REQ-003 SHALL have parameter KEY_COLOR, default 12'hF0F, transparent RGB value.
REQ-004 SHALL have port clk  input  1  pixel clock; all flops on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port xpos  input  11  requested sprite left column.
REQ-007 SHALL have port ypos  input  11  requested sprite top line.
REQ-008 SHALL have port rom_addr  output  $clog2(SPRITE_W*SPRITE_H)  sprite ROM read address, registered.
REQ-009 SHALL have port rom_data  input  12  sprite ROM pixel; synchronous ROM, valid one clk after rom_addr.
REQ-010 SHALL have port in  vga_if.in  -  upstream timing/pixel bus (hcount, vcount 11b; hsync, vsync, hblnk, vblnk 1b; rgb 12b).
REQ-011 SHALL have port out  vga_if.out  -  downstream bus, same fields.

Function
REQ-012 SHALL hold position registers xpos_q, ypos_q; load from xpos/ypos only on the cycle where in.vblnk=1 and the stage-0 copy of vblnk from the previous cycle was 0 (rising edge); otherwise hold.
REQ-013 SHALL compute inside = (in.hcount >= xpos_q) & (in.hcount < xpos_q+SPRITE_W) & (in.vcount >= ypos_q) & (in.vcount < ypos_q+SPRITE_H) & !in.hblnk & !in.vblnk, with sums in 12 bits (no wrap for xpos/ypos up to 2047).
REQ-014 SHALL register stage 1: all in fields, inside, and rom_addr = (in.vcount-ypos_q)*SPRITE_W + (in.hcount-xpos_q), truncated to rom_addr width; when inside=0 rom_addr SHALL be 0.
REQ-015 SHALL register stage 2: out.hcount, vcount, hsync, vsync, hblnk, vblnk = stage-1 values.
REQ-016 SHALL drive out.rgb (stage 2) = rom_data when stage-1 inside=1 and rom_data != KEY_COLOR, else stage-1 rgb.
REQ-017 SHALL have fixed latency of exactly 2 clk from in to out for every field, including during blanking.
REQ-018 SHALL not alter hsync/vsync/hblnk/vblnk/hcount/vcount values, only delay them.
REQ-019 Sprite partially off-screen (xpos+SPRITE_W > visible width) SHALL draw only visible columns; blanked pixels never overwritten.
REQ-020 xpos/ypos change mid-frame SHALL have no effect on drawing until next vblnk rising edge (no tearing).
REQ-021 Pixel at column xpos_q+SPRITE_W-1 SHALL be drawn; column xpos_q+SPRITE_W SHALL not.

Reset
REQ-022 SHALL, while rst=0, asynchronously clear all out fields, stage-1 registers, inside, rom_addr, xpos_q, ypos_q, and the vblnk edge detector to 0.
REQ-023 SHALL resume on first clk after rst deasserts with pipeline refilling; out valid 2 clk later; no position load until a vblnk rising edge is seen after reset.
REQ-024 Reset asserted mid-frame SHALL drop all in-flight pixels; no partial sprite state retained.

Verification
REQ-025 Latency: drive in.hcount=100, vcount=50, hsync=1, rgb=12'h123 for one clk, sprite away -> out shows same values exactly 2 clk later, rgb=12'h123.
REQ-026 Draw: xpos=200, ypos=100 loaded at vblnk edge; in at (hcount=205, vcount=103) -> rom_addr=3*32+5=101 after 1 clk; rom_data=12'hABC -> out.rgb=12'hABC after 2 clk.
REQ-027 Transparency: same setup, rom_data=12'hF0F, in.rgb=12'h0F0 -> out.rgb=12'h0F0.
REQ-028 Boundaries: xpos=200; hcount=231 -> drawn (rom_addr col 31); hcount=232 and 199 -> in.rgb passed, rom_addr=0; hblnk=1 inside box -> in.rgb passed.
REQ-029 Latch timing: change xpos 200->300 mid-frame -> sprite stays at 200 until vblnk rises, then column 300 next frame.
REQ-030 Reset: assert rst=0 mid-line with sprite active -> out fields all 0 immediately (before next clk edge), xpos_q=0; after release out follows in with 2-clk latency.
